uart_vram_loader: RTL
=====================

// Module: uart_vram_loader
// PURPOSE
//  Packet-based loader between uart_rx and mode_mux user port. Parses command bytes from the
//  UART receiver and drives VRAM writes (addressed bursts, hardware fill) and video mode select.
//  Generalises the free-running byte-to-VRAM counter: random addressing, configurable VRAM depth,
//  hardware fill, mode set over UART, inter-byte timeout and error reporting.
// PARAMETERS
//  ADDR_W          15       VRAM address width
//  VRAM_DEPTH      22500    number of VRAM locations; address wraps VRAM_DEPTH-1 -> 0
//  MODE_W          3        width of mode select
//  MODE_RESET      1        mode value after reset
//  TIMEOUT_CYCLES  100000   max clk10m cycles between bytes of one packet (10 ms at 10 MHz)
// PORTS
//  clk10m      in   1       system clock; sole clock domain
//  rst         in   1       synchronous, active-high reset
//  rx_data     in   8       byte from uart_rx
//  rx_valid    in   1       uart_rx data_ready, level, held until acked
//  rx_ack      out  1       one-cycle consume pulse to uart_rx data_ack
//  vram_addr   out  ADDR_W  VRAM write address
//  vram_data   out  8       VRAM write data
//  vram_we     out  1       VRAM write strobe, one cycle per location
//  mode        out  MODE_W  video mode to mode_mux
//  busy        out  1       high whenever state != IDLE
//  err         out  1       sticky error flag; cleared by reset or CLR_ERR command
//  byte_led    out  1       toggles on every consumed byte
// BEHAVIOUR
//  Reset: rx_ack=0, vram_we=0, vram_addr=0, vram_data=0, mode=MODE_RESET, busy=0, err=0,
//   byte_led=0, state=IDLE, pointer=0, timeout counter=0. Reset mid-packet/mid-fill aborts it.
//  Byte accept: when rx_valid=1, rx_ack was 0 last cycle, and state is not FILLING. Accept cycle
//   asserts rx_ack next cycle for exactly 1 cycle. rx_valid ignored in cycle after rx_ack.
//  Opcodes (in IDLE): 0x01 SET_ADDR lo,hi | 0x02 WRITE len,data[len] (len=0 means 256) |
//   0x03 SET_MODE m | 0x04 FILL cnt_lo,cnt_hi,val (cnt=0 -> no writes) | 0x05 CLR_ERR.
//   Other opcodes: err<=1, stay IDLE.
//  States: IDLE, ADDR_LO, ADDR_HI, LEN, DATA, MODE, FILL_LO, FILL_HI, FILL_VAL, FILLING.
//  SET_ADDR: {hi,lo}[ADDR_W-1:0] loaded into pointer on hi byte; value >= VRAM_DEPTH -> err<=1,
//   pointer unchanged. Upper bits beyond ADDR_W ignored.
//  DATA: each accepted byte -> next cycle vram_we=1, vram_addr=pointer, vram_data=byte; pointer
//   advances with wrap (pointer==VRAM_DEPTH-1 -> 0). Return to IDLE after len-th byte.
//  SET_MODE: mode <= m[MODE_W-1:0] on accept; back to IDLE.
//  FILLING: one write per cycle, vram_data=val, consecutive wrapping addresses, cnt writes total;
//   no bytes accepted (rx_ack held 0); first write the cycle after val accepted.
//  Pointer after WRITE/FILL = address following last written; persists for next command.
//  Timeout: counter resets on each accepted byte, counts in any state except IDLE/FILLING;
//   reaching TIMEOUT_CYCLES -> state=IDLE, err<=1, partial writes kept.
//  vram_we never asserted outside DATA/FILLING; at most one write per cycle.
// TESTING
//  SET_ADDR 0x10,0x00; WRITE 3,'A','B','C' -> writes 0x41@16,0x42@17,0x43@18; busy low after.
//  SET_ADDR 22498; WRITE 3,1,2,3 -> writes @22498,22499,0 (wrap); err stays 0.
//  FILL 0x05,0x00,0xAA at ptr 0 -> vram_we high 5 consecutive cycles, addr 0..4, data 0xAA.
//  SET_MODE 2 -> mode=2; opcode 0x7F -> err=1; CLR_ERR -> err=0; SET_ADDR 30000 -> err=1.
//  WRITE 4 then only 1 data byte, wait 100000 cycles -> state IDLE, err=1, one write done.
//  rst asserted mid-FILL of 100 -> next cycle vram_we=0, addr=0, mode=1, busy=0.

Source files
------------

// File: rtl/uart_vram_loader_if.sv
// UART receive handshake and VRAM write port of the loader.
// master: the loader (consumes rx bytes, drives VRAM writes).
// slave:  the byte source / VRAM side.
interface uart_vram_loader_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_data;
    logic              vram_we;

    modport master (
        input  rx_data, rx_valid,
        output rx_ack, vram_addr, vram_data, vram_we
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ack, vram_addr, vram_data, vram_we
    );
endinterface

// File: rtl/uart_vram_loader.sv
// Packet loader: parses command bytes from uart_rx and issues VRAM writes
// (addressed bursts and hardware fill), mode selection and error reporting.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for an opcode byte
// ADDR_LO   | SET_ADDR, waiting for address low byte
// ADDR_HI   | SET_ADDR, waiting for address high byte
// LEN       | WRITE, waiting for length byte (0 means 256)
// DATA      | WRITE, each byte becomes one VRAM write
// MODE      | SET_MODE, waiting for mode byte
// FILL_LO   | FILL, waiting for count low byte
// FILL_HI   | FILL, waiting for count high byte
// FILL_VAL  | FILL, waiting for fill value
// FILLING   | one write per cycle, no bytes consumed
module uart_vram_loader #(
    parameter int ADDR_W         = 15,
    parameter int VRAM_DEPTH     = 22500,
    parameter int MODE_W         = 3,
    parameter int MODE_RESET     = 1,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk10m,
    input  logic                rst,
    uart_vram_loader_if.master  bus,
    output logic [MODE_W-1:0]   mode,
    output logic                busy,
    output logic                err,
    output logic                byte_led
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(VRAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C   = ADDR_W'(VRAM_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_LO, S_ADDR_HI, S_LEN, S_DATA,
        S_MODE, S_FILL_LO, S_FILL_HI, S_FILL_VAL, S_FILLING
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [7:0]        data_q, data_d, val_q, val_d, lo_q, lo_d;
    logic              ack_q, ack_d, we_q, we_d, err_q, err_d, led_q, led_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [8:0]        len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              accept, counting, timeout;
    logic [ADDR_W-1:0] ptr_next, new_addr;

    // Rx bytes are taken only when not mid-fill and not in the ack cycle,
    // so a level-held rx_valid is never consumed twice.
    assign accept   = bus.rx_valid && !ack_q && (state_q != S_FILLING);
    assign counting = (state_q != S_IDLE) && (state_q != S_FILLING);
    assign timeout  = counting && !accept && (tmo_q == TMO_LAST);
    assign ptr_next = (ptr_q == LAST_C) ? '0 : ptr_q + 1'b1;
    assign new_addr = ADDR_W'({bus.rx_data, lo_q});

    assign bus.rx_ack    = ack_q;
    assign bus.vram_we   = we_q;
    assign bus.vram_addr = addr_q;
    assign bus.vram_data = data_q;
    assign mode          = mode_q;
    assign err           = err_q;
    assign byte_led      = led_q;
    assign busy          = (state_q != S_IDLE);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk10m) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            val_q   <= '0;
            lo_q    <= '0;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            led_q   <= 1'b0;
            mode_q  <= MODE_W'(MODE_RESET);
            tmo_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            val_q   <= val_d;
            lo_q    <= lo_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            err_q   <= err_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            tmo_q   <= tmo_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Packet parser, write generation and inter-byte timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        val_d   = val_q;
        lo_d    = lo_q;
        ack_d   = 1'b0;
        we_d    = 1'b0;
        err_d   = err_q;
        led_d   = led_q;
        mode_d  = mode_q;
        tmo_d   = '0;
        len_d   = len_q;
        cnt_d   = cnt_q;

        if (accept) begin
            ack_d = 1'b1;
            led_d = ~led_q;
        end else if (counting) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: if (accept) begin
                case (bus.rx_data)
                    8'h01:   state_d = S_ADDR_LO;
                    8'h02:   state_d = S_LEN;
                    8'h03:   state_d = S_MODE;
                    8'h04:   state_d = S_FILL_LO;
                    8'h05:   err_d   = 1'b0;
                    default: err_d   = 1'b1;
                endcase
            end
            S_ADDR_LO: if (accept) begin
                lo_d    = bus.rx_data;
                state_d = S_ADDR_HI;
            end
            S_ADDR_HI: if (accept) begin
                if ({1'b0, new_addr} >= DEPTH_C) err_d = 1'b1;
                else                             ptr_d = new_addr;
                state_d = S_IDLE;
            end
            S_LEN: if (accept) begin
                len_d   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                state_d = S_DATA;
            end
            S_DATA: if (accept) begin
                we_d   = 1'b1;
                addr_d = ptr_q;
                data_d = bus.rx_data;
                ptr_d  = ptr_next;
                len_d  = len_q - 1'b1;
                if (len_q == 9'd1) state_d = S_IDLE;
            end
            S_MODE: if (accept) begin
                mode_d  = bus.rx_data[MODE_W-1:0];
                state_d = S_IDLE;
            end
            S_FILL_LO: if (accept) begin
                lo_d    = bus.rx_data;
                state_d = S_FILL_HI;
            end
            S_FILL_HI: if (accept) begin
                cnt_d   = {bus.rx_data, lo_q};
                state_d = S_FILL_VAL;
            end
            S_FILL_VAL: if (accept) begin
                val_d = bus.rx_data;
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    // First fill write goes out alongside the val ack.
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = bus.rx_data;
                    ptr_d   = ptr_next;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == 16'd1) ? S_IDLE : S_FILLING;
                end
            end
            S_FILLING: begin
                we_d   = 1'b1;
                addr_d = ptr_q;
                data_d = val_q;
                ptr_d  = ptr_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == 16'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end
endmodule
